// File: rtl/input_repeater_bank_if.sv
// Bundles the frame strobe, abort, key levels and command outputs of input_repeater_bank.
// The rel output exists only when INPUT_REPEATER_RELEASE_EN is defined.
interface input_repeater_bank_if #(
   parameter int unsigned NUM_CH = 5
);
   logic              tick_game;
   logic              clear;
   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] cmd;
   logic [NUM_CH-1:0] held;
`ifdef INPUT_REPEATER_RELEASE_EN
   logic [NUM_CH-1:0] rel;

   modport master (output tick_game, clear, raw, input cmd, held, rel);
   modport slave  (input tick_game, clear, raw, output cmd, held, rel);
`else
   modport master (output tick_game, clear, raw, input cmd, held);
   modport slave  (input tick_game, clear, raw, output cmd, held);
`endif
endinterface

// File: rtl/input_repeater_bank.sv
// Per-channel key repeater: a press pulses cmd, then repeat channels auto-fire after
// DAS_DELAY ticks and every DAS_SPEED ticks. Optional rel pulses via INPUT_REPEATER_RELEASE_EN.
module input_repeater_bank #(
   parameter int unsigned       NUM_CH      = 5,
   parameter logic [NUM_CH-1:0] REPEAT_MASK = NUM_CH'(5'b00111),
   parameter int unsigned       DAS_DELAY   = 16,
   parameter int unsigned       DAS_SPEED   = 4
) (
   input logic               clk,
   input logic               rst,
   input_repeater_bank_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

   // Counters stop one short of their limit, so they can never pass 255.
   localparam logic [7:0] DELAY_LAST = 8'(DAS_DELAY - 1);
   localparam logic [7:0] SPEED_LAST = 8'(DAS_SPEED - 1);

   state_t            state_r   [NUM_CH];
   state_t            state_nxt [NUM_CH];
   logic [7:0]        cnt_r     [NUM_CH];
   logic [7:0]        cnt_nxt   [NUM_CH];
   logic [NUM_CH-1:0] prev_r;
   logic [NUM_CH-1:0] cmd_r;
   logic [NUM_CH-1:0] held_r;
   logic [NUM_CH-1:0] cmd_nxt;
   logic [NUM_CH-1:0] held_nxt;
   logic [NUM_CH-1:0] press;

   assign press = bus.raw & ~prev_r;

   always_comb begin
      cmd_nxt  = '0;
      held_nxt = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_nxt[i] = state_r[i];
         cnt_nxt[i]   = cnt_r[i];
         // Release beats clear, which beats any tick or press on the same edge.
         if (!bus.raw[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
         end else if (bus.clear) begin
            state_nxt[i] = LOCK;
            cnt_nxt[i]   = '0;
         end else begin
            case (state_r[i])
               IDLE: begin
                  if (press[i]) begin
                     cmd_nxt[i]   = 1'b1;
                     state_nxt[i] = REPEAT_MASK[i] ? DELAY : LOCK;
                     cnt_nxt[i]   = '0;
                  end
               end
               DELAY: begin
                  if (bus.tick_game) begin
                     if (cnt_r[i] >= DELAY_LAST) begin
                        cmd_nxt[i]   = 1'b1;
                        state_nxt[i] = REPEAT;
                        cnt_nxt[i]   = '0;
                     end else begin
                        cnt_nxt[i] = cnt_r[i] + 8'd1;
                     end
                  end
               end
               REPEAT: begin
                  if (bus.tick_game) begin
                     if (cnt_r[i] >= SPEED_LAST) begin
                        cmd_nxt[i] = 1'b1;
                        cnt_nxt[i] = '0;
                     end else begin
                        cnt_nxt[i] = cnt_r[i] + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
         held_nxt[i] = (state_nxt[i] == DELAY) || (state_nxt[i] == REPEAT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r <= '1;
         cmd_r  <= '0;
         held_r <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_r[i] <= IDLE;
            cnt_r[i]   <= '0;
         end
      end else begin
         prev_r <= bus.raw;
         cmd_r  <= cmd_nxt;
         held_r <= held_nxt;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_r[i] <= state_nxt[i];
            cnt_r[i]   <= cnt_nxt[i];
         end
      end
   end

   assign bus.cmd  = cmd_r;
   assign bus.held = held_r;

`ifdef INPUT_REPEATER_RELEASE_EN
   logic [NUM_CH-1:0] rel_r;
   logic [NUM_CH-1:0] rel_nxt;

   // Gated by a non-IDLE state so the forced-high prev_r after reset cannot fake a release.
   always_comb begin
      rel_nxt = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         rel_nxt[i] = !bus.raw[i] && prev_r[i] && (state_r[i] != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rel_r <= '0;
      end else begin
         rel_r <= rel_nxt;
      end
   end

   assign bus.rel = rel_r;
`endif
endmodule

// File: tb/tb_input_repeater_bank.sv
// Directed bench for input_repeater_bank: a vector table plus long multi-cycle sequences;
// a second instance with DAS_DELAY=DAS_SPEED=1 covers the fastest repeat setting.
module tb_input_repeater_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_repeater_bank_if #(.NUM_CH(5)) bus ();
   input_repeater_bank_if #(.NUM_CH(5)) bus2 ();

   assign bus2.tick_game = bus.tick_game;
   assign bus2.clear     = bus.clear;
   assign bus2.raw       = bus.raw;

   input_repeater_bank #(
      .NUM_CH(5), .REPEAT_MASK(5'b00111), .DAS_DELAY(16), .DAS_SPEED(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   input_repeater_bank #(
      .NUM_CH(5), .REPEAT_MASK(5'b11111), .DAS_DELAY(1), .DAS_SPEED(1)
   ) dut_fast (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   typedef struct {
      logic       tick;
      logic       clr;
      logic [4:0] raw;
      logic [4:0] cmd;
      logic [4:0] held;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs, let the edge pass, then compare cmd and held.
   task automatic cyc(input logic tick, input logic clr, input logic [4:0] r,
                      input logic [4:0] ecmd, input logic [4:0] eheld, input string name);
      bus.tick_game = tick;
      bus.clear     = clr;
      bus.raw       = r;
      @(posedge clk);
      #1;
      chk({name, ".cmd"}, bus.cmd, ecmd);
      chk({name, ".held"}, bus.held, eheld);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[1]  = '{1'b0, 1'b0, 5'b00001, 5'b00001, 5'b00001};
      tbl[2]  = '{1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00001};
      tbl[3]  = '{1'b1, 1'b0, 5'b01000, 5'b01000, 5'b00000};
      tbl[4]  = '{1'b1, 1'b0, 5'b01000, 5'b00000, 5'b00000};
      tbl[5]  = '{1'b0, 1'b0, 5'b10110, 5'b10110, 5'b00110};
      tbl[6]  = '{1'b0, 1'b1, 5'b10110, 5'b00000, 5'b00000};
      tbl[7]  = '{1'b1, 1'b0, 5'b10110, 5'b00000, 5'b00000};
      tbl[8]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[9]  = '{1'b0, 1'b1, 5'b00011, 5'b00000, 5'b00000};
      tbl[10] = '{1'b0, 1'b0, 5'b00011, 5'b00000, 5'b00000};
      tbl[11] = '{1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[12] = '{1'b0, 1'b0, 5'b00011, 5'b00011, 5'b00011};
      tbl[13] = '{1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000};

      bus.tick_game = 1'b0;
      bus.clear     = 1'b0;
      bus.raw       = 5'b00000;
      rst           = 1'b1;
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "reset0");
      cyc(1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00000, "reset1");
      rst = 1'b0;
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "post_reset");

      for (int i = 0; i < 14; i++)
         cyc(tbl[i].tick, tbl[i].clr, tbl[i].raw, tbl[i].cmd, tbl[i].held,
             $sformatf("vec%0d", i));

      // One-shot channel held for 30 ticks: one pulse at the press only.
      cyc(1'b0, 1'b0, 5'b01000, 5'b01000, 5'b00000, "oneshot_press");
      for (int t = 1; t <= 30; t++)
         cyc(1'b1, 1'b0, 5'b01000, 5'b00000, 5'b00000, $sformatf("oneshot_t%0d", t));
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "oneshot_rel");

      // Repeat channel held for 28 ticks with an idle cycle between ticks.
      cyc(1'b0, 1'b0, 5'b00001, 5'b00001, 5'b00001, "das_press");
      chk("fast_press", bus2.cmd, 5'b00001);
      for (int t = 1; t <= 28; t++) begin
         cyc(1'b1, 1'b0, 5'b00001,
             (t >= 16 && (t - 16) % 4 == 0) ? 5'b00001 : 5'b00000,
             5'b00001, $sformatf("das_t%0d", t));
         chk($sformatf("fast_t%0d", t), bus2.cmd, 5'b00001);
         cyc(1'b0, 1'b0, 5'b00001, 5'b00000, 5'b00001, $sformatf("das_gap%0d", t));
         chk($sformatf("fast_gap%0d", t), bus2.cmd, 5'b00000);
      end
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "das_rel");

      // Release coincident with tick 16 wins: no pulse, then a fresh press fires.
      cyc(1'b0, 1'b0, 5'b00001, 5'b00001, 5'b00001, "relwin_press");
      for (int t = 1; t <= 15; t++)
         cyc(1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00001, $sformatf("relwin_t%0d", t));
      cyc(1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, "relwin_t16");
      cyc(1'b0, 1'b0, 5'b00001, 5'b00001, 5'b00001, "relwin_repress");
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "relwin_rel");

      // Clear at tick 10 locks the channel until it is released.
      cyc(1'b0, 1'b0, 5'b00010, 5'b00010, 5'b00010, "clr_press");
      for (int t = 1; t <= 9; t++)
         cyc(1'b1, 1'b0, 5'b00010, 5'b00000, 5'b00010, $sformatf("clr_t%0d", t));
      cyc(1'b1, 1'b1, 5'b00010, 5'b00000, 5'b00000, "clr_t10");
      for (int t = 11; t <= 40; t++)
         cyc(1'b1, 1'b0, 5'b00010, 5'b00000, 5'b00000, $sformatf("clr_t%0d", t));
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "clr_rel");
      cyc(1'b0, 1'b0, 5'b00010, 5'b00010, 5'b00010, "clr_repress");
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "clr_rel2");

      // Reset at tick 18 with two keys held: silence until release and re-press.
      cyc(1'b0, 1'b0, 5'b00011, 5'b00011, 5'b00011, "rst_press");
      for (int t = 1; t <= 17; t++)
         cyc(1'b1, 1'b0, 5'b00011, (t == 16) ? 5'b00011 : 5'b00000, 5'b00011,
             $sformatf("rst_t%0d", t));
      rst = 1'b1;
      cyc(1'b1, 1'b0, 5'b00011, 5'b00000, 5'b00000, "rst_t18");
      rst = 1'b0;
      for (int t = 19; t <= 40; t++)
         cyc(1'b1, 1'b0, 5'b00011, 5'b00000, 5'b00000, $sformatf("rst_t%0d", t));
      cyc(1'b0, 1'b0, 5'b00001, 5'b00000, 5'b00000, "rst_rel1");
      cyc(1'b0, 1'b0, 5'b00011, 5'b00010, 5'b00010, "rst_repress1");
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "rst_relall");

`ifdef INPUT_REPEATER_RELEASE_EN
      cyc(1'b0, 1'b0, 5'b10000, 5'b10000, 5'b00000, "rel_press");
      chk("rel_press.rel", bus.rel, 5'b00000);
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "rel_fall");
      chk("rel_fall.rel", bus.rel, 5'b10000);
      cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, "rel_after");
      chk("rel_after.rel", bus.rel, 5'b00000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
